div_seq: RTL and testbench

Iterative 32-bit divide/remainder sequencer for the 3-stage RISC-V core. It sits beside the EX-stage ALU. When the control unit decodes an M-extension DIV/DIVU/REM/REMU (aluop 1110/1111), this block takes over the operation and holds the pipeline with `stall_EX` while a radix-2 restoring divider runs. It releases the pipeline with a one-cycle `done` and a RISC-V-compliant result.

---
 rtl/div_seq.sv | 164 ++++++++++++++++
 tb/tb_div_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative radix-2 restoring divide/remainder sequencer for the EX stage
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             stall_EX,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_IT  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONE = '1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;       // partial remainder, always < |b| between iterations
    logic [WIDTH-1:0] quot;      // quotient bits shifted in LSB-first
    logic [WIDTH-1:0] dvd;       // |a|, consumed MSB-first
    logic [WIDTH-1:0] div_mag;   // |b|
    logic             a_sign;
    logic             b_sign;
    logic             op_rem;    // funct3[1]: 1 selects remainder

    // Operand decode in IDLE; funct3[2] is ignored so 0xx aliases 1xx
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             sgn_ovf;

    always_comb begin
        is_signed = ~funct3[0];
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        a_mag     = a_neg ? (~a + ONE) : a;
        b_mag     = b_neg ? (~b + ONE) : b;
        div_zero  = (b == '0);
        sgn_ovf   = is_signed & (a == MIN_NEG) & (b == ALL_ONE);
    end

    // One restoring step: shift the next dividend bit in and try to subtract |b|
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, div_mag};
    end

    // Sign correction: quotient negative on sign mismatch, remainder follows dividend
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        q_fix = (a_sign ^ b_sign) ? (~quot + ONE) : quot;
        r_fix = a_sign ? (~rem + ONE) : rem;
    end

    // Pipeline hold: asserted from the accepting cycle until the cycle before DONE
    always_comb begin
        stall_EX = ((state == S_IDLE) & start & ~kill)
                 | (state == S_RUN)
                 | (state == S_FIX);
    end

    // Sequencer FSM with registered busy/done/result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rem     <= '0;
            quot    <= '0;
            dvd     <= '0;
            div_mag <= '0;
            a_sign  <= 1'b0;
            b_sign  <= 1'b0;
            op_rem  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else if (kill) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_rem  <= funct3[1];
                        a_sign  <= a_neg;
                        b_sign  <= b_neg;
                        dvd     <= a_mag;
                        div_mag <= b_mag;
                        cnt     <= '0;
                        rem     <= '0;
                        quot    <= '0;
                        busy    <= 1'b1;
                        if (div_zero) begin
                            result <= funct3[1] ? a : ALL_ONE;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else if (sgn_ovf) begin
                            result <= funct3[1] ? '0 : MIN_NEG;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                    cnt <= cnt + CW'(1);
                    if (!trial[WIDTH]) begin
                        rem  <= trial[WIDTH-1:0];
                        quot <= {quot[WIDTH-2:0], 1'b1};
                    end else begin
                        rem  <= shifted[WIDTH-1:0];
                        quot <= {quot[WIDTH-2:0], 1'b0};
                    end
                    if (cnt == LAST_IT) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result <= op_rem ? r_fix : q_fix;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b101;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        kill = 1'b0;
    logic        stall_EX;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = '0;

    div_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .funct3   (funct3),
        .a        (a),
        .b        (b),
        .kill     (kill),
        .stall_EX (stall_EX),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics via wide signed/unsigned arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        if (y == 32'd0) return f3[1] ? x : 32'hFFFF_FFFF;
        if (!f3[0]) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q  = sx / sy;
            r  = sx % sy;
            return f3[1] ? r[31:0] : q[31:0];
        end
        return f3[1] ? (x % y) : (x / y);
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return 1;
        if (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one operation in IDLE and follow it to its done pulse
    task automatic do_op(input logic [2:0] f3, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] exp, input int lat, input string nm, input bit noise);
        int cyc;
        bit st_ok;
        @(negedge clk);
        start = 1'b1; funct3 = f3; a = aa; b = bb;
        #1 st_ok = (stall_EX === 1'b1);
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom);
        cyc = 1;
        while (done !== 1'b1 && cyc < 60) begin
            if (stall_EX !== 1'b1 || busy !== 1'b1) st_ok = 1'b0;
            if (noise && cyc == 5) begin
                start = 1'b1; a = $urandom; b = $urandom_range(1, 9); funct3 = 3'b111;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({nm, " latency"}, 32'(cyc), 32'(lat));
        chk({nm, " result"}, result, exp);
        chk({nm, " stall/busy"}, 32'({st_ok, stall_EX, busy}), 32'b101);
        last_res = exp;
        @(posedge clk); #1;
        chk({nm, " idle after done"}, 32'({done, busy}), 32'b00);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{3'b101, 32'd100,        32'd7,          32'd14,         34, "DIVU 100/7"});
        vecs.push_back('{3'b111, 32'd100,        32'd7,          32'd2,          34, "REMU 100/7"});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, "DIV -7/2"});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, "REM -7/2"});
        vecs.push_back('{3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          34, "REM 7/-2"});
        vecs.push_back('{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  "DIVU 5/0"});
        vecs.push_back('{3'b111, 32'd5,          32'd0,          32'd5,          1,  "REMU 5/0"});
        vecs.push_back('{3'b100, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1,  "DIV -1/0"});
        vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  "DIV ovf"});
        vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  "REM ovf"});
        vecs.push_back('{3'b001, 32'd9,          32'd3,          32'd3,          34, "alias DIVU 9/3"});
        vecs.push_back('{3'b100, 32'h8000_0000,  32'd1,          32'h8000_0000,  34, "DIV min/1"});
        vecs.push_back('{3'b111, 32'hFFFF_FFFF,  32'h10,         32'hF,          34, "REMU max/16"});
        vecs.push_back('{3'b101, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          34, "DIVU max/max"});

        // Reset state
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset stall_EX", 32'(stall_EX), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[i])
            do_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name, 1'b0);

        // Start pulsed mid-RUN must not disturb the in-flight divide
        do_op(3'b101, 32'd100, 32'd7, 32'd14, 34, "start while busy", 1'b1);

        // Kill in cycle 10 of a DIVU
        begin
            int cyc;
            logic [31:0] prior;
            prior = last_res;
            @(negedge clk);
            start = 1'b1; funct3 = 3'b101; a = 32'd1000; b = 32'd3;
            @(posedge clk); #1;
            start = 1'b0;
            for (cyc = 1; cyc < 10; cyc++) begin
                @(posedge clk); #1;
            end
            kill = 1'b1;
            @(posedge clk); #1;
            kill = 1'b0;
            chk("kill busy", 32'(busy), 32'd0);
            chk("kill stall_EX", 32'(stall_EX), 32'd0);
            chk("kill done", 32'(done), 32'd0);
            chk("kill result kept", result, prior);
            cyc = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (done === 1'b1) cyc++;
            end
            chk("kill no late done", 32'(cyc), 32'd0);
        end
        do_op(3'b101, 32'd9, 32'd3, 32'd3, 34, "restart DIVU 9/3", 1'b0);

        // Kill together with start in IDLE
        begin
            int ndone;
            @(negedge clk);
            start = 1'b1; kill = 1'b1; funct3 = 3'b101; a = 32'd50; b = 32'd5;
            #1 chk("kill+start stall_EX", 32'(stall_EX), 32'd0);
            @(posedge clk); #1;
            start = 1'b0; kill = 1'b0;
            chk("kill+start busy", 32'(busy), 32'd0);
            ndone = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (done === 1'b1) ndone++;
            end
            chk("kill+start no done", 32'(ndone), 32'd0);
            chk("kill+start result kept", result, 32'd3);
        end

        // Asynchronous reset in cycle 20 of RUN
        begin
            @(negedge clk);
            start = 1'b1; funct3 = 3'b101; a = 32'd77; b = 32'd5;
            @(posedge clk); #1;
            start = 1'b0;
            for (int k = 1; k < 20; k++) begin
                @(posedge clk); #1;
            end
            rst_n = 1'b0;
            #1;
            chk("async reset outputs", 32'({busy, done, stall_EX}), 32'd0);
            chk("async reset result", result, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            last_res = '0;
        end
        do_op(3'b111, 32'd77, 32'd5, 32'd2, 34, "after reset REMU 77/5", 1'b0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] x;
            logic [31:0] y;
            f3 = {($urandom_range(0, 3) != 0), 2'($urandom)};
            case ($urandom_range(0, 7))
                0: begin x = $urandom; y = 32'd0; end
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: begin x = $urandom; y = 32'($urandom_range(1, 20)); end
                3: begin x = $urandom; y = 32'hFFFF_FFFF - 32'($urandom_range(0, 5)); end
                default: begin x = $urandom; y = $urandom >> $urandom_range(0, 31); end
            endcase
            do_op(f3, x, y, ref_res(f3, x, y), ref_lat(f3, x, y), $sformatf("rand%0d f3=%0d", i, f3), i[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
